// File: rtl/tone_scheduler.sv
// Buzzer tone owner: arbitrates UART notes against the hourly chime and times each phase.
// Optional TONE_SCHED_PREEMPT_EN: a chime trigger during a note aborts the note immediately.
//
// state     | meaning
// IDLE      | tone silent, UART notes accepted unless a chime is pending
// NOTE      | UART note (or rest) held for NOTE_MS
// CHIME_ON  | beep sounding CHIME_TONE for BEEP_ON_MS
// CHIME_OFF | gap between beeps for BEEP_OFF_MS
module tone_scheduler #(
  parameter int         TICK_DIV    = 12000,
  parameter int         NOTE_MS     = 250,
  parameter int         BEEP_ON_MS  = 500,
  parameter int         BEEP_OFF_MS = 500,
  parameter logic [4:0] CHIME_TONE  = 5'h11
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       note_valid,
  input  logic [4:0] note_tone,
  output logic       note_ready,
  input  logic       chime_en,
  input  logic [3:0] time_hour_high,
  input  logic [3:0] time_hour_low,
  input  logic [3:0] time_min_high,
  input  logic [3:0] time_min_low,
  output logic [4:0] tone,
  output logic       busy,
  output logic       chime_active
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_NOTE      = 2'd1;
  localparam logic [1:0] ST_CHIME_ON  = 2'd2;
  localparam logic [1:0] ST_CHIME_OFF = 2'd3;

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_W  = 16;

  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0]  r_ms;
  logic [7:0]       r_prev_min;
  logic             r_pending;
  logic [3:0]       r_beeps;
  logic [3:0]       r_n;
  logic [4:0]       r_tone;

  logic [1:0]       w_state_nxt;
  logic [4:0]       w_tone_nxt;
  logic             w_start_chime;
  logic             w_set_pending;
  logic             w_beep_inc;
  logic [MS_W-1:0]  w_ms_load;
  logic             w_trigger;
  logic             w_phase_done;
  logic             w_ready;
  logic             w_accept;
  logic             w_pend_go;
  logic             w_latch_n;
  logic [7:0]       w_hour;
  logic [7:0]       w_hour_mod;
  logic [3:0]       w_beep_n;

  assign w_trigger    = chime_en && ({time_min_high, time_min_low} == 8'h00) &&
                        (r_prev_min != 8'h00);
  assign w_hour       = 8'(time_hour_high) * 8'd10 + 8'(time_hour_low);
  assign w_hour_mod   = w_hour % 8'd12;
  assign w_beep_n     = (w_hour_mod == 8'd0) ? 4'd12 : w_hour_mod[3:0];
  assign w_phase_done = (r_pre == '0) && (r_ms == '0);
  // Ready drops combinationally on a trigger so a same-cycle note is never handshaken.
  assign w_ready      = !sys_rst && (r_state == ST_IDLE) && !r_pending && !w_trigger;
  assign w_accept     = note_valid && w_ready;
  assign w_pend_go    = r_pending && chime_en;
  assign w_latch_n    = w_trigger && ((r_state == ST_IDLE) || (r_state == ST_NOTE));

  always_comb begin
    w_state_nxt   = r_state;
    w_tone_nxt    = r_tone;
    w_start_chime = 1'b0;
    w_set_pending = 1'b0;
    w_beep_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger || w_pend_go) begin
          w_state_nxt   = ST_CHIME_ON;
          w_tone_nxt    = CHIME_TONE;
          w_start_chime = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_NOTE;
          w_tone_nxt  = note_tone;
        end
      end
      ST_NOTE: begin
`ifdef TONE_SCHED_PREEMPT_EN
        if (w_trigger) begin
          w_state_nxt   = ST_CHIME_ON;
          w_tone_nxt    = CHIME_TONE;
          w_start_chime = 1'b1;
        end else if (w_phase_done) begin
          w_state_nxt = ST_IDLE;
          w_tone_nxt  = 5'h00;
        end
`else
        w_set_pending = w_trigger;
        if (w_phase_done) begin
          w_state_nxt = ST_IDLE;
          w_tone_nxt  = 5'h00;
        end
`endif
      end
      ST_CHIME_ON: begin
        if (!chime_en) begin
          w_state_nxt = ST_IDLE;
          w_tone_nxt  = 5'h00;
        end else if (w_phase_done) begin
          w_state_nxt = ST_CHIME_OFF;
          w_tone_nxt  = 5'h00;
          w_beep_inc  = 1'b1;
        end
      end
      ST_CHIME_OFF: begin
        if (!chime_en) begin
          w_state_nxt = ST_IDLE;
          w_tone_nxt  = 5'h00;
        end else if (w_phase_done) begin
          if (r_beeps == r_n) begin
            w_state_nxt = ST_IDLE;
            w_tone_nxt  = 5'h00;
          end else begin
            w_state_nxt = ST_CHIME_ON;
            w_tone_nxt  = CHIME_TONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tone_nxt  = 5'h00;
      end
    endcase
  end

  always_comb begin
    w_ms_load = '0;
    case (w_state_nxt)
      ST_NOTE:      w_ms_load = MS_W'(NOTE_MS - 1);
      ST_CHIME_ON:  w_ms_load = MS_W'(BEEP_ON_MS - 1);
      ST_CHIME_OFF: w_ms_load = MS_W'(BEEP_OFF_MS - 1);
      default:      w_ms_load = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_tone     <= 5'h00;
      r_pending  <= 1'b0;
      r_prev_min <= 8'h00;
      r_beeps    <= 4'd0;
      r_n        <= 4'd0;
      r_pre      <= '0;
      r_ms       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tone     <= w_tone_nxt;
      r_prev_min <= {time_min_high, time_min_low};

      if (!chime_en || w_start_chime)
        r_pending <= 1'b0;
      else if (w_set_pending)
        r_pending <= 1'b1;

      if (w_latch_n)
        r_n <= w_beep_n;

      if (w_start_chime)
        r_beeps <= 4'd0;
      else if (w_beep_inc)
        r_beeps <= r_beeps + 4'd1;

      // Down-counting ms timer reloads on every state entry; done at prescaler and ms both zero.
      if (w_state_nxt != r_state) begin
        r_pre <= PRE_W'(TICK_DIV - 1);
        r_ms  <= w_ms_load;
      end else if (r_state != ST_IDLE) begin
        if (r_pre == '0) begin
          r_pre <= PRE_W'(TICK_DIV - 1);
          r_ms  <= r_ms - MS_W'(1);
        end else begin
          r_pre <= r_pre - PRE_W'(1);
        end
      end
    end
  end

  assign note_ready   = w_ready;
  assign tone         = r_tone;
  assign busy         = (r_state != ST_IDLE);
  assign chime_active = (r_state == ST_CHIME_ON) || (r_state == ST_CHIME_OFF);

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed scenarios then random traffic, each cycle checked
// against a cycle-count/beeps-remaining reference model.
module tb_tone_scheduler;

  localparam int         TICK_DIV = 4;
  localparam int         NOTE_MS  = 3;
  localparam int         ON_MS    = 2;
  localparam int         OFF_MS   = 2;
  localparam logic [4:0] CT       = 5'h11;
  localparam int         NOTE_CYC = NOTE_MS * TICK_DIV;
  localparam int         ON_CYC   = ON_MS * TICK_DIV;
  localparam int         OFF_CYC  = OFF_MS * TICK_DIV;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       note_valid = 1'b0;
  logic [4:0] note_tone = 5'h00;
  logic       note_ready;
  logic       chime_en = 1'b1;
  logic [3:0] hh = 4'd0, hl = 4'd0, mh = 4'd3, ml = 4'd0;
  logic [4:0] tone;
  logic       busy;
  logic       chime_active;

  int checks = 0;
  int failures = 0;
  int cnt_ct, cnt_busy, cnt_tone;
  logic [4:0] watch_tone;

  tone_scheduler #(
    .TICK_DIV(TICK_DIV), .NOTE_MS(NOTE_MS), .BEEP_ON_MS(ON_MS),
    .BEEP_OFF_MS(OFF_MS), .CHIME_TONE(CT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .note_valid(note_valid), .note_tone(note_tone), .note_ready(note_ready),
    .chime_en(chime_en),
    .time_hour_high(hh), .time_hour_low(hl),
    .time_min_high(mh), .time_min_low(ml),
    .tone(tone), .busy(busy), .chime_active(chime_active)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {P_IDLE, P_NOTE, P_BEEP, P_GAP} phase_t;
  phase_t     m_phase = P_IDLE;
  int         m_left = 0;
  int         m_beeps_left = 0;
  int         m_n_pend = 0;
  bit         m_pend = 1'b0;
  logic [4:0] m_tone = 5'h00;
  logic [7:0] m_prev = 8'h00;

  function automatic int hour_n(int h_hi, int h_lo);
    int r;
    r = (h_hi * 10 + h_lo) % 12;
    return (r == 0) ? 12 : r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_chime(input int n);
    m_phase      = P_BEEP;
    m_left       = ON_CYC;
    m_tone       = CT;
    m_beeps_left = n;
    m_pend       = 1'b0;
  endtask

  task automatic go_idle();
    m_phase = P_IDLE;
    m_tone  = 5'h00;
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after.
  task automatic cyc();
    bit trig, rdy;
    #1;
    trig = chime_en && ({mh, ml} == 8'h00) && (m_prev != 8'h00);
    rdy  = !sys_rst && (m_phase == P_IDLE) && !m_pend && !trig;
    chk("note_ready", {7'd0, note_ready}, {7'd0, rdy});
    if (sys_rst) begin
      go_idle();
      m_pend = 1'b0;
      m_prev = 8'h00;
    end else begin
      if (!chime_en) m_pend = 1'b0;
      case (m_phase)
        P_IDLE: begin
          if (trig) start_chime(hour_n(hh, hl));
          else if (m_pend && chime_en) start_chime(m_n_pend);
          else if (note_valid && rdy) begin
            m_phase = P_NOTE;
            m_left  = NOTE_CYC;
            m_tone  = note_tone;
          end
        end
        P_NOTE: begin
`ifdef TONE_SCHED_PREEMPT_EN
          if (trig) start_chime(hour_n(hh, hl));
          else begin
            m_left--;
            if (m_left == 0) go_idle();
          end
`else
          if (trig) begin
            m_pend   = 1'b1;
            m_n_pend = hour_n(hh, hl);
          end
          m_left--;
          if (m_left == 0) go_idle();
`endif
        end
        P_BEEP: begin
          if (!chime_en) go_idle();
          else begin
            m_left--;
            if (m_left == 0) begin
              m_beeps_left--;
              m_phase = P_GAP;
              m_left  = OFF_CYC;
              m_tone  = 5'h00;
            end
          end
        end
        P_GAP: begin
          if (!chime_en) go_idle();
          else begin
            m_left--;
            if (m_left == 0) begin
              if (m_beeps_left == 0) go_idle();
              else begin
                m_phase = P_BEEP;
                m_left  = ON_CYC;
                m_tone  = CT;
              end
            end
          end
        end
        default: go_idle();
      endcase
      m_prev = {mh, ml};
    end
    @(posedge sys_clk);
    #1;
    chk("tone", {3'd0, tone}, {3'd0, m_tone});
    chk("busy", {7'd0, busy}, {7'd0, m_phase != P_IDLE});
    chk("chime_active", {7'd0, chime_active},
        {7'd0, (m_phase == P_BEEP) || (m_phase == P_GAP)});
    if (tone === CT) cnt_ct++;
    if (tone === watch_tone) cnt_tone++;
    if (busy === 1'b1) cnt_busy++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_counts();
    cnt_ct = 0; cnt_busy = 0; cnt_tone = 0;
  endtask

  // Minute rollover 59 -> 00 at the given hour.
  task automatic rollover(input logic [3:0] h_hi, input logic [3:0] h_lo);
    hh = h_hi; hl = h_lo;
    mh = 4'd5; ml = 4'd9;
    cyc();
    mh = 4'd0; ml = 4'd0;
  endtask

  initial begin
    watch_tone = 5'h07;
    clr_counts();

    // Reset
    sys_rst = 1'b1;
    run(3);
    chk("rst_tone", {3'd0, tone}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    sys_rst = 1'b0;
    #1;
    chk("ready_after_rst", {7'd0, note_ready}, 8'h01);

    // Single note 07
    clr_counts();
    note_valid = 1'b1; note_tone = 5'h07;
    cyc();
    note_valid = 1'b0;
    run(NOTE_CYC + 3);
    chk("note07_cycles", 8'(cnt_tone), 8'(NOTE_CYC));

    // Chime at 14h: 2 beeps
    clr_counts();
    rollover(4'd1, 4'd4);
    run(2 * (ON_CYC + OFF_CYC) + 4);
    chk("chime14_on_cycles", 8'(cnt_ct), 8'(2 * ON_CYC));
    chk("chime14_busy_cycles", 8'(cnt_busy), 8'(2 * (ON_CYC + OFF_CYC)));

    // Chime at 00h: 12 beeps
    clr_counts();
    rollover(4'd0, 4'd0);
    run(12 * (ON_CYC + OFF_CYC) + 4);
    chk("chime00_on_cycles", 8'(cnt_ct), 8'(12 * ON_CYC));

    // Trigger and note in the same cycle (13h -> 1 beep); note held valid throughout
    rollover(4'd1, 4'd3);
    note_valid = 1'b1; note_tone = 5'h05;
    cyc();
    chk("trig_note_tone", {3'd0, tone}, {3'd0, CT});
    run(ON_CYC + OFF_CYC + 1);
    note_valid = 1'b0;
    run(NOTE_CYC + 2);

    // Trigger four cycles into a note (02h -> 2 beeps)
    mh = 4'd4; ml = 4'd5;
    cyc();
    note_valid = 1'b1; note_tone = 5'h09;
    cyc();
    note_valid = 1'b0;
    run(3);
    hh = 4'd0; hl = 4'd2; mh = 4'd0; ml = 4'd0;
    cyc();
`ifdef TONE_SCHED_PREEMPT_EN
    chk("preempt_tone", {3'd0, tone}, {3'd0, CT});
`else
    chk("pending_tone", {3'd0, tone}, 8'h09);
`endif
    run(NOTE_CYC + 2 * (ON_CYC + OFF_CYC) + 4);

    // chime_en dropped during the second beep, then minutes stay at 00
    rollover(4'd1, 4'd4);
    run(ON_CYC + OFF_CYC + 3);
    chime_en = 1'b0;
    cyc();
    chk("en_drop_busy", {7'd0, busy}, 8'h00);
    chk("en_drop_tone", {3'd0, tone}, 8'h00);
    chime_en = 1'b1;
    clr_counts();
    run(20);
    chk("no_retrigger", 8'(cnt_busy), 8'h00);

    // Reset mid-beep, minutes already 00 afterwards (20h -> 8 beeps)
    rollover(4'd2, 4'd0);
    run(5);
    sys_rst = 1'b1;
    cyc();
    chk("midrst_tone", {3'd0, tone}, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    sys_rst = 1'b0;
    clr_counts();
    run(20);
    chk("postrst_no_trigger", 8'(cnt_busy), 8'h00);

    // Random traffic, including out-of-range hours
    for (int i = 0; i < 4000; i++) begin
      note_valid = ($urandom_range(0, 3) == 0);
      note_tone  = 5'($urandom_range(0, 31));
      chime_en   = ($urandom_range(0, 499) != 0);
      sys_rst    = ($urandom_range(0, 1499) == 0);
      if ({mh, ml} == 8'h00) begin
        if ($urandom_range(0, 39) == 0) begin
          mh = 4'($urandom_range(0, 5));
          ml = 4'($urandom_range(1, 9));
        end
      end else if ($urandom_range(0, 59) == 0) begin
        mh = 4'd0; ml = 4'd0;
        hh = 4'($urandom_range(0, 3));
        hl = 4'($urandom_range(0, 15));
      end
      cyc();
    end
    sys_rst = 1'b0;
    note_valid = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
